mask_sched: RTL

MASK_SCHED -- requirements
Module: mask_sched

---
 rtl/mask_sched_if.sv | 25 ++
 rtl/mask_sched.sv | 108 ++++++++++
 2 files changed

// File: rtl/mask_sched_if.sv
// Request/result bus for mask_sched: N packed requesters in, one registered result out.
interface mask_sched_if #(
    parameter int W = 16,
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_mask;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    done_cnt;

    modport slave (
        input  req_valid, req_a, req_mask, out_ready,
        output req_ready, out_data, out_id, out_valid, done_cnt
    );

    modport master (
        output req_valid, req_a, req_mask, out_ready,
        input  req_ready, out_data, out_id, out_valid, done_cnt
    );
endinterface

// File: rtl/mask_sched.sv
// Round-robin shared masking unit: grants one requester, registers a & mask with its id.
// Optional completion counter on done_cnt enabled by `define MASK_SCHED_STATS_EN.
module mask_sched #(
    parameter int W = 16,
    parameter int N = 4
) (
    input logic         clk,
    input logic         rst_n,
    mask_sched_if.slave bus
);
    localparam int unsigned NU = N;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e         state_q;
    logic [W-1:0]   data_q;
    logic [1:0]     id_q;
    logic [1:0]     ptr_q;

    logic           accept_en;
    logic           found;
    logic [N-1:0]   grant;
    logic [1:0]     gnt_idx;
    logic [W-1:0]   job_and [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_and
            assign job_and[gi] = bus.req_a[gi*W +: W] & bus.req_mask[gi*W +: W];
        end
    endgenerate

    assign accept_en = (state_q == IDLE) || bus.out_ready;

    // Search starts one past the last winner so every requester gets its turn.
    always_comb begin
        int unsigned cand_full;
        logic [1:0]  cand;
        grant     = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand_full = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand_full = (32'(ptr_q) + k) % NU;
            cand      = cand_full[1:0];
            if (!found && bus.req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    assign bus.req_ready = accept_en ? grant : '0;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.out_valid = (state_q == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= 2'(N - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= HOLD;
                        data_q  <= job_and[gnt_idx];
                        id_q    <= gnt_idx;
                        ptr_q   <= gnt_idx;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (found) begin
                            data_q <= job_and[gnt_idx];
                            id_q   <= gnt_idx;
                            ptr_q  <= gnt_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MASK_SCHED_STATS_EN
    logic [15:0] done_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
        end else if ((state_q == HOLD) && bus.out_ready) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign bus.done_cnt = done_cnt_q;
`else
    assign bus.done_cnt = '0;
`endif

endmodule
